// File: rtl/sdc_cmd_framer_if.sv
// Command/shift-register bundle for sdc_cmd_framer.
// slave: the framer itself; master: the command source and shift-register side.
interface sdc_cmd_framer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [47:0] frame;
  logic        sr_load;
  logic        sr_shift;
  logic        sr_msb;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, sr_msb,
    output cmd_ready, frame, sr_load, sr_shift, cmd_out, cmd_oe, busy, done
  );

  modport master (
    output cmd_valid, cmd_index, cmd_arg, sr_msb,
    input  cmd_ready, frame, sr_load, sr_shift, cmd_out, cmd_oe, busy, done
  );
endinterface

// File: rtl/sdc_cmd_framer.sv
// SD command framer: accepts {index, arg}, computes CRC7 (x^7+x^3+1), builds the
// 48-bit frame, loads the external shift register and paces 47 shift pulses at
// one bit per DIV clocks while driving the CMD line enable.
// Build option SDC_CMD_FAST_CRC_EN: CRC7 computed combinationally in a single
// CRC cycle instead of 40 serial cycles; frame content is unchanged.
module sdc_cmd_framer #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  sdc_cmd_framer_if.slave cmd_if
);

  typedef enum logic [2:0] {IDLE, CRC, LOAD, SEND, DONE} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_t           state;
  logic [47:0]      frame_q;
  logic [6:0]       crc_q;
  logic [DIV_W-1:0] div_q;
  logic [5:0]       bit_q;
  logic             ready_q;
  logic             load_q;
  logic             shift_q;
  logic             oe_q;
  logic             busy_q;
  logic             done_q;

`ifdef SDC_CMD_FAST_CRC_EN
  // Same bit-serial recurrence as the slow path, unrolled over all 40 bits.
  function automatic logic [6:0] crc7_calc(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = d[39 - i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction
`else
  logic       crc_bit;
  logic [6:0] crc_next;

  // One CRC7 step over the frame bit selected by the bit counter (MSB first).
  always_comb begin
    crc_bit  = frame_q[6'd47 - bit_q];
    crc_next = {crc_q[5:0], 1'b0} ^ ((crc_bit ^ crc_q[6]) ? 7'h09 : 7'h00);
  end
`endif

  // Control FSM with registered handshake, shift-register strobes and line enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      frame_q <= '0;
      crc_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ready_q <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_if.cmd_valid && ready_q) begin
            frame_q <= {1'b0, 1'b1, cmd_if.cmd_index, cmd_if.cmd_arg, 7'h00, 1'b1};
            crc_q   <= '0;
            bit_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= CRC;
          end else begin
            ready_q <= 1'b1;
          end
        end
        CRC: begin
`ifdef SDC_CMD_FAST_CRC_EN
          crc_q        <= crc7_calc(frame_q[47:8]);
          frame_q[7:1] <= crc7_calc(frame_q[47:8]);
          load_q       <= 1'b1;
          state        <= LOAD;
`else
          crc_q <= crc_next;
          if (bit_q == 6'd39) begin
            frame_q[7:1] <= crc_next;
            bit_q        <= '0;
            load_q       <= 1'b1;
            state        <= LOAD;
          end else begin
            bit_q <= bit_q + 6'd1;
          end
`endif
        end
        LOAD: begin
          oe_q  <= 1'b1;
          div_q <= '0;
          bit_q <= '0;
          state <= SEND;
        end
        SEND: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q == 6'd47) begin
              oe_q   <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              bit_q <= bit_q + 6'd1;
            end
          end else begin
            div_q <= div_q + 1'b1;
            // Registered one cycle early so the pulse coincides with div_q == DIV_LAST.
            shift_q <= (div_q == DIV_LAST - 1'b1) && (bit_q < 6'd47);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_ready = ready_q;
  assign cmd_if.frame     = frame_q;
  assign cmd_if.sr_load   = load_q;
  assign cmd_if.sr_shift  = shift_q;
  assign cmd_if.cmd_oe    = oe_q;
  assign cmd_if.cmd_out   = oe_q ? cmd_if.sr_msb : 1'b1;
  assign cmd_if.busy      = busy_q;
  assign cmd_if.done      = done_q;

endmodule

// File: tb/tb_sdc_cmd_framer.sv
// Self-checking bench for sdc_cmd_framer: DIV=4 instance for the main tests,
// DIV=2 instance for back-to-back framing. Each instance has a behavioural
// shift-register model and a line/strobe monitor.
module tb_sdc_cmd_framer;

`ifdef SDC_CMD_FAST_CRC_EN
  localparam int CRC_CYC = 1;
`else
  localparam int CRC_CYC = 40;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sdc_cmd_framer_if bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int D = (g == 0) ? 4 : 2;

    sdc_cmd_framer #(.DIV(D), .DIV_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .cmd_if(bus[g])
    );

    logic [47:0] sr = '0;
    always @(posedge clock or negedge reset) begin
      if (!reset)               sr <= '0;
      else if (bus[g].sr_load)  sr <= bus[g].frame;
      else if (bus[g].sr_shift) sr <= {sr[46:0], 1'b0};
    end
    assign bus[g].sr_msb = sr[47];

    int shifts = 0, loads = 0, dones = 0, overlap = 0, unstable = 0, ready_busy = 0;
    int hs_cnt = 0, hs_cyc = 0, load_cyc = 0, done_cyc = 0, oe_pos = 0, last_oe = 0;
    logic [47:0] cap  = '0;
    logic        bitv = 1'b1;

    always @(posedge clock) begin
      if (reset && bus[g].cmd_valid && bus[g].cmd_ready) begin
        hs_cnt <= hs_cnt + 1;
        hs_cyc <= cyc + 1;
      end
    end

    always @(negedge clock) begin
      if (bus[g].sr_shift) shifts <= shifts + 1;
      if (bus[g].sr_load) begin
        loads    <= loads + 1;
        load_cyc <= cyc;
      end
      if (bus[g].done) begin
        dones    <= dones + 1;
        done_cyc <= cyc;
      end
      if (bus[g].sr_load && bus[g].sr_shift) overlap <= overlap + 1;
      if (bus[g].cmd_ready && bus[g].busy) ready_busy <= ready_busy + 1;
      if (bus[g].cmd_oe) begin
        if (oe_pos % D == 0) bitv <= bus[g].cmd_out;
        else if (bus[g].cmd_out != bitv) unstable <= unstable + 1;
        if (oe_pos % D == D - 1) cap <= {cap[46:0], bus[g].cmd_out};
        oe_pos <= oe_pos + 1;
      end else if (oe_pos != 0) begin
        last_oe <= oe_pos;
        oe_pos  <= 0;
      end
    end
  end

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [4];
  int snap_shift, snap_load, snap_done, snap_hs;

  // Reference: CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    logic [46:0] r;
    m = {2'b01, idx, arg};
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return {m, r[6:0], 1'b1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic start0(input logic [5:0] idx, input logic [31:0] arg);
    int n;
    n = 0;
    while (!bus[0].cmd_ready && n < 400) begin
      tick();
      n++;
    end
    chk("ready_wait", bus[0].cmd_ready, 1);
    snap_shift = g_u[0].shifts;
    snap_load  = g_u[0].loads;
    snap_done  = g_u[0].dones;
    snap_hs    = g_u[0].hs_cnt;
    bus[0].cmd_index = idx;
    bus[0].cmd_arg   = arg;
    bus[0].cmd_valid = 1'b1;
    tick();
    bus[0].cmd_valid = 1'b0;
    chk("handshake", g_u[0].hs_cnt, snap_hs + 1);
    snap_hs = g_u[0].hs_cnt;
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    while (g_u[0].dones == snap_done && n < 600) begin
      tick();
      n++;
    end
    chk("done_wait", g_u[0].dones, snap_done + 1);
  endtask

  task automatic check0(input string name, input logic [47:0] exp);
    chk({name, "_frame"}, bus[0].frame, exp);
    chk({name, "_line"}, g_u[0].cap, exp);
    chk({name, "_shifts"}, g_u[0].shifts - snap_shift, 47);
    chk({name, "_loads"}, g_u[0].loads - snap_load, 1);
    chk({name, "_oe_len"}, g_u[0].last_oe, 48 * 4);
    chk({name, "_load_lat"}, g_u[0].load_cyc - g_u[0].hs_cyc + 1, CRC_CYC + 1);
    chk({name, "_done_lat"}, g_u[0].done_cyc - g_u[0].hs_cyc + 1, CRC_CYC + 2 + 48 * 4);
    chk({name, "_overlap"}, g_u[0].overlap, 0);
    chk({name, "_unstable"}, g_u[0].unstable, 0);
    chk({name, "_ready_busy"}, g_u[0].ready_busy, 0);
  endtask

  initial begin
    int n, h, d, s, dcyc;
    logic [5:0]  ridx;
    logic [31:0] rarg;

    vecs[0] = '{idx: 6'd0,  arg: 32'h0000_0000, exp: 48'h4000_0000_0095};
    vecs[1] = '{idx: 6'd8,  arg: 32'h0000_01AA, exp: 48'h4800_0001_AA87};
    vecs[2] = '{idx: 6'd17, arg: 32'h0000_0000, exp: 48'h5100_0000_0055};
    vecs[3] = '{idx: 6'd55, arg: 32'h0000_0000, exp: 48'h7700_0000_0065};

    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        bus[0].cmd_valid = 1'b0; bus[0].cmd_index = '0; bus[0].cmd_arg = '0;
      end else begin
        bus[1].cmd_valid = 1'b0; bus[1].cmd_index = '0; bus[1].cmd_arg = '0;
      end
    end

    // Reset state
    tick(); tick();
    chk("rst_flags", {bus[0].cmd_ready, bus[0].sr_load, bus[0].sr_shift, bus[0].cmd_oe,
                      bus[0].cmd_out, bus[0].busy, bus[0].done}, 7'b0000100);
    chk("rst_frame", bus[0].frame, 48'h0);
    reset = 1'b1;
    chk("ready_pre_edge", bus[0].cmd_ready, 0);
    tick();
    chk("ready_post_edge", bus[0].cmd_ready, 1);

    // Table-driven frames at DIV=4
    for (int i = 0; i < 4; i++) begin
      start0(vecs[i].idx, vecs[i].arg);
      chk("busy_after_hs", {bus[0].busy, bus[0].cmd_ready}, 2'b10);
      wait_done0();
      check0($sformatf("vec%0d", i), vecs[i].exp);
    end

    // cmd_valid while busy is ignored (during CRC and during SEND)
    start0(6'd8, 32'h1AA);
    repeat (5) tick();
    bus[0].cmd_index = 6'd17; bus[0].cmd_arg = 32'hDEAD_BEEF; bus[0].cmd_valid = 1'b1;
    tick();
    chk("ign_crc_ready", bus[0].cmd_ready, 0);
    bus[0].cmd_valid = 1'b0;
    n = 0;
    while (g_u[0].oe_pos < 40 && n < 300) begin tick(); n++; end
    chk("ign_reach_send", bus[0].cmd_oe, 1);
    bus[0].cmd_valid = 1'b1;
    tick(); tick();
    chk("ign_send_ready", bus[0].cmd_ready, 0);
    bus[0].cmd_valid = 1'b0;
    wait_done0();
    check0("ignore", 48'h4800_0001_AA87);
    repeat (5) tick();
    chk("ign_no_second", g_u[0].hs_cnt, snap_hs);

    // Reset mid-frame at SEND bit 20
    start0(6'd55, 32'h0);
    n = 0;
    while (g_u[0].oe_pos < 20 * 4 + 2 && n < 300) begin tick(); n++; end
    chk("abort_reach", bus[0].cmd_oe, 1);
    d = g_u[0].dones;
    #2 reset = 1'b0;
    #1;
    chk("abort_line", {bus[0].cmd_oe, bus[0].cmd_out}, 2'b01);
    chk("abort_flags", {bus[0].busy, bus[0].cmd_ready}, 2'b00);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("abort_ready", bus[0].cmd_ready, 1);
    chk("abort_no_done", g_u[0].dones, d);
    start0(6'd0, 32'h0);
    wait_done0();
    check0("after_abort", 48'h4000_0000_0095);

    // Randomized commands against the division-based model
    for (int i = 0; i < 5; i++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      start0(ridx, rarg);
      wait_done0();
      check0($sformatf("rand%0d", i), model_frame(ridx, rarg));
    end

    // Back-to-back with cmd_valid held high, DIV=2
    h = g_u[1].hs_cnt; d = g_u[1].dones; s = g_u[1].shifts;
    bus[1].cmd_index = 6'd17; bus[1].cmd_arg = 32'h0; bus[1].cmd_valid = 1'b1;
    n = 0;
    while (g_u[1].hs_cnt == h && n < 20) begin tick(); n++; end
    chk("b2b_hs1", g_u[1].hs_cnt, h + 1);
    bus[1].cmd_index = 6'd8; bus[1].cmd_arg = 32'h1AA;
    n = 0;
    while (g_u[1].dones == d && n < 400) begin tick(); n++; end
    chk("b2b_frame1", bus[1].frame, 48'h5100_0000_0055);
    chk("b2b_line1", g_u[1].cap, 48'h5100_0000_0055);
    chk("b2b_oe_len1", g_u[1].last_oe, 96);
    chk("b2b_done_lat1", g_u[1].done_cyc - g_u[1].hs_cyc + 1, CRC_CYC + 2 + 96);
    dcyc = g_u[1].done_cyc;
    n = 0;
    while (g_u[1].hs_cnt == h + 1 && n < 10) begin tick(); n++; end
    chk("b2b_hs_gap", g_u[1].hs_cyc - dcyc, 2);
    bus[1].cmd_valid = 1'b0;
    n = 0;
    while (g_u[1].dones < d + 2 && n < 400) begin tick(); n++; end
    chk("b2b_frame2", bus[1].frame, 48'h4800_0001_AA87);
    chk("b2b_line2", g_u[1].cap, 48'h4800_0001_AA87);
    chk("b2b_oe_len2", g_u[1].last_oe, 96);
    chk("b2b_shifts", g_u[1].shifts - s, 94);
    chk("b2b_overlap", g_u[1].overlap, 0);
    chk("b2b_unstable", g_u[1].unstable, 0);
    chk("b2b_dones", g_u[1].dones, d + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdc_cmd_framer.md
Name: sdc_cmd_framer

Overview:
Upstream feeder for the 48-bit SDC shift register. Accepts a command index and argument over a valid/ready handshake, then computes CRC7 bit-serially. It assembles the 48-bit SD command frame, parallel-loads it into the shift register, and paces 47 shift pulses so the frame goes out MSB-first on the CMD line at clock/DIV.

Parameters:
DIV, 4, clock cycles per serial bit period; legal range 2..255.
DIV_W, 8, width of the bit-period divider counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  block idle and able to accept a command.
cmd_index  in  6  command index; captured on handshake.
cmd_arg  in  32  command argument; captured on handshake.
frame  out  48  to shift register data_in_p: {1'b0, 1'b1, index, arg, crc7, 1'b1}.
sr_load  out  1  to shift register load; one-cycle pulse.
sr_shift  out  1  to shift register shift; one-cycle pulses.
sr_msb  in  1  shift register data_out[47]; current line bit.
cmd_out  out  1  CMD line data: sr_msb when cmd_oe=1, else 1.
cmd_oe  out  1  CMD line output enable.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the frame has been fully sent.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; frame=0, crc=0, counters=0.
  - Outputs during reset: cmd_ready=0, sr_load=0, sr_shift=0, cmd_oe=0, cmd_out=1, busy=0, done=0.
- cmd_ready is registered. It goes to 1 on the first clock edge after reset releases and is 1 only in IDLE.
- Handshake: accepted on the edge where cmd_valid & cmd_ready. That edge captures index and arg, clears crc to 0, and moves to CRC. cmd_ready drops the next cycle.
- cmd_valid outside IDLE is ignored. Nothing is queued.
- CRC state: 40 cycles, one bit per edge, MSB-first over {0, 1, index, arg}.
  - Polynomial x^7+x^3+1.
  - Update: fb = bit ^ crc[6]; crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 0).
  - frame[47:8] is valid from the cycle after handshake. frame[7:1] is written on the 40th edge.
  - Next state: LOAD.
- LOAD: sr_load=1 for exactly one cycle, then SEND.
- SEND:
  - cmd_oe=1 for exactly 48*DIV cycles, starting the cycle after LOAD.
  - Divider counts 0..DIV-1. A bit counter counts 0..47.
  - sr_shift=1 on the cycle where divider==DIV-1 and bit counter<47. Exactly 47 shift pulses per frame.
  - On divider==DIV-1 with bit counter==47, the next state is DONE.
- DONE: done=1 and cmd_oe=0 for one cycle, then IDLE (cmd_ready=1 the next cycle).
- frame holds its value from LOAD until the next handshake.
- sr_load and sr_shift are never high in the same cycle.
- Latency from handshake edge: sr_load high in cycle +41; done in cycle +42+48*DIV.
- Reset mid-frame: immediate abort. cmd_oe=0 asynchronously and no done pulse. After release, back to IDLE with cmd_ready=1.
- Back-to-back: cmd_valid held high gives a new handshake the cycle after done, so the line has at least 2 idle cycles between frames.

Optional Feature:
SDC_CMD_FAST_CRC_EN
- Defined: CRC7 over all 40 bits is computed combinationally from the captured fields. The CRC state lasts 1 cycle, so sr_load is high in cycle +2 and done in cycle +3+48*DIV. Frame content is identical.
- Undefined: serial 40-cycle CRC as described under Behaviour.

Test Plan:
- CMD0, arg 0x00000000, DIV=4 -> frame=0x400000000095; cmd_out sequence 0,1,0...; exactly 47 sr_shift pulses; cmd_oe high 192 cycles; done at handshake+234.
- CMD8, arg 0x000001AA -> frame=0x48000001AA87. CMD17, arg 0 -> frame=0x510000000055. CMD55, arg 0 -> frame=0x770000000065.
- cmd_valid pulsed while busy (during CRC and during SEND) -> ignored; cmd_ready=0; only the first frame is sent.
- reset asserted at SEND bit 20 -> cmd_oe=0 and cmd_out=1 immediately; no done pulse; cmd_ready=1 on first edge after release; next CMD0 frame is correct.
- cmd_valid held high for two commands -> second handshake the cycle after done; sr_load and sr_shift never overlap; DIV=2 gives 96-cycle cmd_oe windows.
- With SDC_CMD_FAST_CRC_EN defined, CMD8 arg 0x1AA -> same frame 0x48000001AA87; sr_load at handshake+2.
